// File: rtl/fnd_arbiter.sv
// Shares one 4-digit FND between a background value and two timed messages (lo, hi).
// Each granted message is held for HOLD_MS ticks; hi messages blink with a BLINK_MS half-period.
module fnd_arbiter #(
  parameter int TICK_DIV = 100_000,
  parameter int HOLD_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data_bg,
  input  logic        req_lo,
  input  logic [11:0] data_lo,
  input  logic        req_hi,
  input  logic [11:0] data_hi,
  output logic [11:0] disp_value,
  output logic [1:0]  disp_src,
  output logic        disp_blank,
  output logic        busy,
  output logic        grant_lo,
  output logic        grant_hi
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_MS  > 1) ? $clog2(HOLD_MS)  : 1;
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [1:0] SRC_BG = 2'd0;
  localparam logic [1:0] SRC_LO = 2'd1;
  localparam logic [1:0] SRC_HI = 2'd2;

  typedef enum logic {SHOW_BG, HOLD} state_t;

  state_t        state_q, state_d;
  logic          pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
  logic [11:0]   slot_lo_q, slot_lo_d, slot_hi_q, slot_hi_d;
  logic [11:0]   disp_value_q, disp_value_d;
  logic [1:0]    disp_src_q, disp_src_d;
  logic          disp_blank_q, disp_blank_d;
  logic          grant_lo_q, grant_lo_d, grant_hi_q, grant_hi_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  logic tick, expire, preempt, arb, gnt_hi, gnt_lo, rereq_hi, rereq_lo;

  always_comb begin
    tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
    expire   = (state_q == HOLD) && tick && (hold_cnt_q == HW'(HOLD_MS - 1));
    preempt  = (state_q == HOLD) && (disp_src_q == SRC_LO) && pend_hi_q && !expire;
    arb      = (state_q == SHOW_BG) || expire;
    gnt_hi   = (arb && pend_hi_q) || preempt;
    gnt_lo   = arb && !pend_hi_q && pend_lo_q;
    // A request from the source on screen restarts its hold at once instead of queueing.
    rereq_hi = req_hi && (state_q == HOLD) && (disp_src_q == SRC_HI) && !expire;
    rereq_lo = req_lo && (state_q == HOLD) && (disp_src_q == SRC_LO) && !expire && !pend_hi_q;
  end

  always_comb begin
    state_d      = state_q;
    pend_lo_d    = pend_lo_q;
    pend_hi_d    = pend_hi_q;
    slot_lo_d    = slot_lo_q;
    slot_hi_d    = slot_hi_q;
    disp_value_d = disp_value_q;
    disp_src_d   = disp_src_q;
    disp_blank_d = disp_blank_q;
    grant_lo_d   = 1'b0;
    grant_hi_d   = 1'b0;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
    hold_cnt_d   = hold_cnt_q;
    blink_cnt_d  = blink_cnt_q;

    if (gnt_hi || rereq_hi || gnt_lo || rereq_lo) begin
      state_d      = HOLD;
      hold_cnt_d   = '0;
      tick_cnt_d   = '0;
      blink_cnt_d  = '0;
      disp_blank_d = 1'b0;
      if (gnt_hi || rereq_hi) begin
        disp_src_d   = SRC_HI;
        grant_hi_d   = 1'b1;
        disp_value_d = gnt_hi ? slot_hi_q : data_hi;
        pend_hi_d    = pend_hi_q && !gnt_hi;
      end else begin
        disp_src_d   = SRC_LO;
        grant_lo_d   = 1'b1;
        disp_value_d = gnt_lo ? slot_lo_q : data_lo;
        pend_lo_d    = pend_lo_q && !gnt_lo;
      end
    end else if (arb) begin
      state_d      = SHOW_BG;
      disp_value_d = data_bg;
      disp_src_d   = SRC_BG;
      disp_blank_d = 1'b0;
    end else if (tick) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      if (disp_src_q == SRC_HI) begin
        if (blink_cnt_q == BW'(BLINK_MS - 1)) begin
          blink_cnt_d  = '0;
          disp_blank_d = !disp_blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end

    // Newest request value always wins the slot; the pending flag is left alone on a restart.
    if (req_hi) slot_hi_d = data_hi;
    if (req_lo) slot_lo_d = data_lo;
    if (req_hi && !rereq_hi) pend_hi_d = 1'b1;
    if (req_lo && !rereq_lo) pend_lo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SHOW_BG;
      pend_lo_q    <= 1'b0;
      pend_hi_q    <= 1'b0;
      slot_lo_q    <= '0;
      slot_hi_q    <= '0;
      disp_value_q <= '0;
      disp_src_q   <= SRC_BG;
      disp_blank_q <= 1'b0;
      grant_lo_q   <= 1'b0;
      grant_hi_q   <= 1'b0;
      tick_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_lo_q    <= pend_lo_d;
      pend_hi_q    <= pend_hi_d;
      slot_lo_q    <= slot_lo_d;
      slot_hi_q    <= slot_hi_d;
      disp_value_q <= disp_value_d;
      disp_src_q   <= disp_src_d;
      disp_blank_q <= disp_blank_d;
      grant_lo_q   <= grant_lo_d;
      grant_hi_q   <= grant_hi_d;
      tick_cnt_q   <= tick_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_src   = disp_src_q;
  assign disp_blank = disp_blank_q;
  assign busy       = (state_q == HOLD);
  assign grant_lo   = grant_lo_q;
  assign grant_hi   = grant_hi_q;

endmodule

// File: tb/tb_fnd_arbiter.sv
// Bench for fnd_arbiter with TICK_DIV=10, HOLD_MS=4, BLINK_MS=1 (hold = 40 cycles, blink every 10).
// Expected outputs are queued when stimulus is driven and popped one cycle later at sample time.
module tb_fnd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] data_bg = 12'd123;
  logic        req_lo = 1'b0, req_hi = 1'b0;
  logic [11:0] data_lo = '0, data_hi = '0;
  logic [11:0] disp_value;
  logic [1:0]  disp_src;
  logic        disp_blank, busy, grant_lo, grant_hi;

  always #5 clk = ~clk;

  fnd_arbiter #(.TICK_DIV(10), .HOLD_MS(4), .BLINK_MS(1)) dut (
    .clk(clk), .reset(reset), .data_bg(data_bg),
    .req_lo(req_lo), .data_lo(data_lo), .req_hi(req_hi), .data_hi(data_hi),
    .disp_value(disp_value), .disp_src(disp_src), .disp_blank(disp_blank),
    .busy(busy), .grant_lo(grant_lo), .grant_hi(grant_hi)
  );

  typedef struct packed {
    logic [11:0] val;
    logic [1:0]  src;
    logic        blank;
    logic        busy;
    logic        glo;
    logic        ghi;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        rlo;
    logic [11:0] dlo;
    logic        rhi;
    logic [11:0] dhi;
    int          n;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t ex(input int v, input int s, input bit b, input bit bz,
                              input bit gl, input bit gh);
    exp_t e;
    e.val = 12'(v); e.src = 2'(s); e.blank = b; e.busy = bz; e.glo = gl; e.ghi = gh;
    return e;
  endfunction

  function automatic vec_t mk(input string nm, input bit rst, input bit rlo, input int dlo,
                              input bit rhi, input int dhi, input int n, input exp_t e);
    vec_t v;
    v.name = nm; v.rst = rst; v.rlo = rlo; v.dlo = 12'(dlo);
    v.rhi = rhi; v.dhi = 12'(dhi); v.n = n; v.e = e;
    return v;
  endfunction

  task automatic compare(input string nm);
    exp_t e, a;
    e = sb_q.pop_front();
    a.val = disp_value; a.src = disp_src; a.blank = disp_blank;
    a.busy = busy; a.glo = grant_lo; a.ghi = grant_hi;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got val=%0d src=%0d blank=%b busy=%b glo=%b ghi=%b, want val=%0d src=%0d blank=%b busy=%b glo=%b ghi=%b",
               nm, $time, a.val, a.src, a.blank, a.busy, a.glo, a.ghi,
               e.val, e.src, e.blank, e.busy, e.glo, e.ghi);
    end
  endtask

  task automatic cyc(input string nm, input logic rst, input logic rlo, input logic [11:0] dlo,
                     input logic rhi, input logic [11:0] dhi, input exp_t e);
    @(negedge clk);
    reset = rst; req_lo = rlo; data_lo = dlo; req_hi = rhi; data_hi = dhi;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(nm);
  endtask

  task automatic run(input string nm, input int n, input exp_t e);
    for (int k = 0; k < n; k++) cyc(nm, 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, e);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1);
  end

  initial begin
    // Reset, release, single lo message
    tbl.push_back(mk("rst_held",   0, 0,  0, 0,   0,  3, ex(0,   0, 0, 0, 0, 0)));
    tbl.push_back(mk("rst_rel",    1, 0,  0, 0,   0,  1, ex(123, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("lo_req",     1, 1, 45, 0,   0,  1, ex(123, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("lo_gnt",     1, 0,  0, 0,   0,  1, ex(45,  1, 0, 1, 1, 0)));
    tbl.push_back(mk("lo_hold",    1, 0,  0, 0,   0, 39, ex(45,  1, 0, 1, 0, 0)));
    tbl.push_back(mk("lo_end",     1, 0,  0, 0,   0,  3, ex(123, 0, 0, 0, 0, 0)));
    // hi preempts lo, blinks, lo not re-shown
    tbl.push_back(mk("pre_lo_req", 1, 1, 45, 0,   0,  1, ex(123, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("pre_lo_gnt", 1, 0,  0, 0,   0,  1, ex(45,  1, 0, 1, 1, 0)));
    tbl.push_back(mk("pre_lo_hld", 1, 0,  0, 0,   0, 14, ex(45,  1, 0, 1, 0, 0)));
    tbl.push_back(mk("pre_hi_req", 1, 0,  0, 1, 999,  1, ex(45,  1, 0, 1, 0, 0)));
    tbl.push_back(mk("pre_hi_gnt", 1, 0,  0, 0,   0,  1, ex(999, 2, 0, 1, 0, 1)));
    tbl.push_back(mk("pre_blk0a",  1, 0,  0, 0,   0,  9, ex(999, 2, 0, 1, 0, 0)));
    tbl.push_back(mk("pre_blk1a",  1, 0,  0, 0,   0, 10, ex(999, 2, 1, 1, 0, 0)));
    tbl.push_back(mk("pre_blk0b",  1, 0,  0, 0,   0, 10, ex(999, 2, 0, 1, 0, 0)));
    tbl.push_back(mk("pre_blk1b",  1, 0,  0, 0,   0, 10, ex(999, 2, 1, 1, 0, 0)));
    tbl.push_back(mk("pre_end",    1, 0,  0, 0,   0,  5, ex(123, 0, 0, 0, 0, 0)));
    // Simultaneous hi and lo
    tbl.push_back(mk("sim_req",    1, 1,  8, 1,   7,  1, ex(123, 0, 0, 0, 0, 0)));
    tbl.push_back(mk("sim_hi_gnt", 1, 0,  0, 0,   0,  1, ex(7,   2, 0, 1, 0, 1)));
    tbl.push_back(mk("sim_blk0a",  1, 0,  0, 0,   0,  9, ex(7,   2, 0, 1, 0, 0)));
    tbl.push_back(mk("sim_blk1a",  1, 0,  0, 0,   0, 10, ex(7,   2, 1, 1, 0, 0)));
    tbl.push_back(mk("sim_blk0b",  1, 0,  0, 0,   0, 10, ex(7,   2, 0, 1, 0, 0)));
    tbl.push_back(mk("sim_blk1b",  1, 0,  0, 0,   0, 10, ex(7,   2, 1, 1, 0, 0)));
    tbl.push_back(mk("sim_lo_gnt", 1, 0,  0, 0,   0,  1, ex(8,   1, 0, 1, 1, 0)));
    tbl.push_back(mk("sim_lo_hld", 1, 0,  0, 0,   0, 39, ex(8,   1, 0, 1, 0, 0)));
    tbl.push_back(mk("sim_end",    1, 0,  0, 0,   0,  3, ex(123, 0, 0, 0, 0, 0)));

    for (int i = 0; i < tbl.size(); i++)
      for (int j = 0; j < tbl[i].n; j++)
        cyc(tbl[i].name, tbl[i].rst, (j == 0) ? tbl[i].rlo : 1'b0, tbl[i].dlo,
            (j == 0) ? tbl[i].rhi : 1'b0, tbl[i].dhi, tbl[i].e);

    // Reset mid-hold with a lo message pending behind hi
    cyc("mr_hi_req", 1'b1, 1'b0, 12'd0, 1'b1, 12'd7, ex(123, 0, 0, 0, 0, 0));
    cyc("mr_hi_gnt", 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, ex(7, 2, 0, 1, 0, 1));
    cyc("mr_lo_req", 1'b1, 1'b1, 12'd9, 1'b0, 12'd0, ex(7, 2, 0, 1, 0, 0));
    run("mr_hold", 5, ex(7, 2, 0, 1, 0, 0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(ex(0, 0, 0, 0, 0, 0));
    compare("async_rst");
    cyc("mr_rst_held", 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, ex(0, 0, 0, 0, 0, 0));
    cyc("mr_rst_held", 1'b0, 1'b0, 12'd0, 1'b0, 12'd0, ex(0, 0, 0, 0, 0, 0));
    data_bg = 12'd321;
    cyc("mr_release", 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, ex(321, 0, 0, 0, 0, 0));
    run("mr_no_stale", 50, ex(321, 0, 0, 0, 0, 0));

    // Re-request by the held lo source restarts the hold
    cyc("rr_req5", 1'b1, 1'b1, 12'd5, 1'b0, 12'd0, ex(321, 0, 0, 0, 0, 0));
    cyc("rr_gnt5", 1'b1, 1'b0, 12'd0, 1'b0, 12'd0, ex(5, 1, 0, 1, 1, 0));
    run("rr_hold5", 19, ex(5, 1, 0, 1, 0, 0));
    cyc("rr_req6", 1'b1, 1'b1, 12'd6, 1'b0, 12'd0, ex(6, 1, 0, 1, 1, 0));
    run("rr_hold6", 39, ex(6, 1, 0, 1, 0, 0));
    run("rr_end", 3, ex(321, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
